// File: rtl/proc_pkg.sv
// Shared definitions for the data_proc configuration path.
package proc_pkg;

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_INV  = 2'b01;
    localparam logic [1:0] MODE_CONV = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    localparam int KERNEL_W = 72;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LOAD  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/proc_cfg_sequencer.sv
// Holds host config requests and applies them to data_proc at frame
// boundaries once the producer is stalled and the processor output is quiet.
module proc_cfg_sequencer
    import proc_pkg::*;
#(
    parameter int FRAME_PIX = 4096,
    parameter int QUIET_CYC = 16,
    parameter int CNT_W     = $clog2(FRAME_PIX)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [1:0]          cfg_mode,
    input  logic [KERNEL_W-1:0] cfg_kernel,
    input  logic                src_valid,
    output logic                src_ready,
    output logic                proc_valid,
    input  logic                proc_ready,
    input  logic                out_valid,
    input  logic                out_ready,
    output logic [1:0]          mode,
    output logic [KERNEL_W-1:0] kernel,
    output logic                flush,
    output logic                frame_done,
    output logic [15:0]         frame_cnt,
    output logic                busy
);

    localparam int QW = $clog2(QUIET_CYC) + 1;
    localparam logic [CNT_W-1:0] LAST_PIX   = CNT_W'(FRAME_PIX - 1);
    localparam logic [QW-1:0]    QUIET_LAST = QW'(QUIET_CYC - 1);

    seq_state_t state;
    seq_state_t state_nx;

    logic                pend;
    logic [1:0]          sh_mode;
    logic [KERNEL_W-1:0] sh_kernel;
    logic [CNT_W-1:0]    pix_cnt;
    logic [QW-1:0]       quiet;

    logic gate;
    logic fire;
    logic last_fire;
    logic accept;
    logic load_exit;
    logic out_busy;

    assign fire      = src_valid & src_ready;
    assign last_fire = fire && (pix_cnt == LAST_PIX);
    assign accept    = cfg_valid & cfg_ready;
    assign load_exit = (state == ST_LOAD);
    // A stalled output is still holding data, so it never counts as quiet.
    assign out_busy  = out_valid | (out_valid & ~out_ready);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_RUN;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_RUN: begin
                if ((pend || accept) &&
                    ((pix_cnt == '0 && !fire) || last_fire)) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!out_busy && quiet == QUIET_LAST) begin
                    state_nx = ST_LOAD;
                end
            end
            ST_LOAD:  state_nx = ST_RUN;
            default:  state_nx = ST_RUN;
        endcase
    end

    always_comb begin
        gate       = (state == ST_RUN) && !flush;
        src_ready  = proc_ready & gate;
        proc_valid = src_valid & gate;
        cfg_ready  = !pend;
        busy       = (state != ST_RUN) || flush;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pend       <= 1'b0;
            sh_mode    <= MODE_PASS;
            sh_kernel  <= '0;
            mode       <= MODE_PASS;
            kernel     <= '0;
            flush      <= 1'b0;
            pix_cnt    <= '0;
            quiet      <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            flush      <= load_exit;
            frame_done <= last_fire;
            if (last_fire) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (load_exit) begin
                mode    <= sh_mode;
                kernel  <= sh_kernel;
                pend    <= 1'b0;
                quiet   <= '0;
                pix_cnt <= '0;
            end else begin
                if (accept) begin
                    pend      <= 1'b1;
                    sh_mode   <= cfg_mode;
                    sh_kernel <= cfg_kernel;
                end
                if (fire) begin
                    pix_cnt <= last_fire ? '0 : pix_cnt + 1'b1;
                end
                if (state == ST_DRAIN) begin
                    quiet <= out_busy ? '0 : quiet + 1'b1;
                end else begin
                    quiet <= '0;
                end
            end
        end
    end

endmodule
